// File: rtl/core_pkg.sv
// Shared core types: IF/ID entry layout, fetch FSM states and fault causes.
package core_pkg;

   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   typedef enum logic {RUN, FAULT} fetch_state_e;

   typedef enum logic [1:0] {
      FC_NONE     = 2'd0,
      FC_OOR      = 2'd1,
      FC_MISALIGN = 2'd2
   } fault_cause_e;

   typedef struct packed {
      logic         valid;
      logic [31:0]  inst;
      logic [31:0]  pc;
      logic         fault;
      fault_cause_e cause;
   } if_id_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction memory, redirect from execute, IF/ID handshake to decode.
interface fetch_unit_if;
   logic [31:0] imem_addr_o;
   logic [31:0] imem_inst_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        id_valid_o;
   logic        id_ready_i;
   logic [31:0] id_inst_o;
   logic [31:0] id_pc_o;
   logic        id_fault_o;
   logic [1:0]  id_fault_cause_o;

   modport master (
      output imem_addr_o, id_valid_o, id_inst_o, id_pc_o, id_fault_o, id_fault_cause_o,
      input  imem_inst_i, redirect_i, redirect_pc_i, id_ready_i
   );

   modport slave (
      input  imem_addr_o, id_valid_o, id_inst_o, id_pc_o, id_fault_o, id_fault_cause_o,
      output imem_inst_i, redirect_i, redirect_pc_i, id_ready_i
   );
endinterface

// File: rtl/fetch_unit_pc_gen.sv
// Program counter: next-PC select (redirect / increment / hold), range and alignment checks.
module fetch_unit_pc_gen #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned IMEM_WORDS = 101
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        inc_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic [31:0] pc_o,
   output logic        oor_o,
   output logic        misalign_o
);

   logic [31:0] pc_d, pc_q;

   always_comb begin
      pc_d = pc_q;
      if (redirect_i)
         pc_d = {redirect_pc_i[31:2], 2'b00};
      else if (inc_i)
         pc_d = pc_q + 32'd4;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pc_q <= RESET_PC;
      else        pc_q <= pc_d;
   end

   // Word index compared at full width so huge PCs never alias into range.
   assign oor_o      = {2'b00, pc_q[31:2]} >= IMEM_WORDS;
   assign misalign_o = |redirect_pc_i[1:0];
   assign pc_o       = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// RV32 instruction fetch: PC, IF/ID register with valid/ready, fault halt until redirect.
module fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned IMEM_WORDS = 101,
   parameter logic [31:0] NOP_INST   = core_pkg::NOP_INST
) (
   input  logic          clk,
   input  logic          rst_n,
   fetch_unit_if.master  bus
);
   import core_pkg::*;

   logic         advance, inc, oor, misalign;
   logic [31:0]  pc;
   fetch_state_e state_d, state_q;
   if_id_t       id_d, id_q;

   assign advance = !id_q.valid | bus.id_ready_i;
   assign inc     = !bus.redirect_i && advance && (state_q == RUN) && !oor;

   fetch_unit_pc_gen #(
      .RESET_PC   (RESET_PC),
      .IMEM_WORDS (IMEM_WORDS)
   ) u_pc_gen (
      .clk           (clk),
      .rst_n         (rst_n),
      .inc_i         (inc),
      .redirect_i    (bus.redirect_i),
      .redirect_pc_i (bus.redirect_pc_i),
      .pc_o          (pc),
      .oor_o         (oor),
      .misalign_o    (misalign)
   );

   always_comb begin
      state_d = state_q;
      id_d    = id_q;
      if (bus.redirect_i) begin
         // Redirect beats stall and oor; a misaligned target becomes its own fault entry.
         if (misalign) begin
            id_d    = '{valid: 1'b1, inst: NOP_INST, pc: bus.redirect_pc_i,
                        fault: 1'b1, cause: FC_MISALIGN};
            state_d = FAULT;
         end else begin
            id_d    = '{valid: 1'b0, inst: NOP_INST, pc: bus.redirect_pc_i,
                        fault: 1'b0, cause: FC_NONE};
            state_d = RUN;
         end
      end else if (advance) begin
         case (state_q)
            RUN: begin
               if (oor) begin
                  id_d    = '{valid: 1'b1, inst: NOP_INST, pc: pc,
                              fault: 1'b1, cause: FC_OOR};
                  state_d = FAULT;
               end else begin
                  id_d = '{valid: 1'b1, inst: bus.imem_inst_i, pc: pc,
                           fault: 1'b0, cause: FC_NONE};
               end
            end
            default: begin
               id_d = '{valid: 1'b0, inst: NOP_INST, pc: id_q.pc,
                        fault: 1'b0, cause: FC_NONE};
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         id_q    <= '{valid: 1'b0, inst: NOP_INST, pc: 32'd0, fault: 1'b0, cause: FC_NONE};
      end else begin
         state_q <= state_d;
         id_q    <= id_d;
      end
   end

   assign bus.imem_addr_o      = pc;
   assign bus.id_valid_o       = id_q.valid;
   assign bus.id_inst_o        = id_q.inst;
   assign bus.id_pc_o          = id_q.pc;
   assign bus.id_fault_o       = id_q.fault;
   assign bus.id_fault_cause_o = id_q.cause;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the single-issue RV32 core.
- Owns the program counter and drives the word address of the combinational instruction memory, which returns its word in the same cycle.
- Captures the returned instruction and its PC into the IF/ID register, which feeds decode through a valid/ready handshake.
- Accepts redirects (taken branches, jumps) from execute, flags out-of-range and misaligned fetches, and halts fetch on a fault until the next redirect.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded at reset.
- IMEM_WORDS, 101, instruction memory depth in 32-bit words; valid byte addresses are 0 to 4*IMEM_WORDS-1.
- NOP_INST, 32'h0000_0013, instruction word (addi x0,x0,0) presented on bubbles and faults.

Ports:
- clk, input, 1, core clock, rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- imem_addr_o, output, 32, byte address to the instruction memory; always equal to pc_q.
- imem_inst_i, input, 32, instruction word returned combinationally for imem_addr_o.
- redirect_i, input, 1, execute requests a PC change this cycle.
- redirect_pc_i, input, 32, redirect target byte address.
- id_valid_o, output, 1, IF/ID holds a valid entry.
- id_ready_i, input, 1, decode accepts the entry this cycle.
- id_inst_o, output, 32, registered instruction.
- id_pc_o, output, 32, registered PC of id_inst_o.
- id_fault_o, output, 1, entry is a fetch fault.
- id_fault_cause_o, output, 2, fault cause: 0 none, 1 out-of-range, 2 misaligned.

Behaviour:
- Reset (asynchronous, while rst_n=0): pc_q=RESET_PC, state=RUN, id_valid_o=0, id_inst_o=NOP_INST, id_pc_o=0, id_fault_o=0, id_fault_cause_o=0.
- The first fetch happens in the first rising edge after rst_n deasserts.
- Reset asserted mid-operation discards any in-flight entry immediately (asynchronous clear).
- advance = !id_valid_o | id_ready_i. The IF/ID register loads only when advance=1; otherwise all IF/ID outputs and pc_q hold, which is the stall.
- oor = (pc_q >> 2) >= IMEM_WORDS, computed on the full 32-bit value with no truncation.
- State RUN, advance=1, oor=0: IF/ID <= {valid=1, inst=imem_inst_i, pc=pc_q, fault=0}; pc_q <= pc_q + 4, wrapping modulo 2^32.
- State RUN, advance=1, oor=1: IF/ID <= {valid=1, inst=NOP_INST, pc=pc_q, fault=1, cause=1}; pc_q holds; next state FAULT.
- State FAULT: no new entries are produced. Once the fault entry is consumed, id_valid_o goes to 0 and stays 0. The only exits are redirect and reset.
- Redirect (highest priority, any state, independent of advance):
  - Aligned target (redirect_pc_i[1:0]=0): pc_q <= redirect_pc_i; IF/ID valid <= 0 (flush, inst=NOP_INST); state <= RUN.
  - Misaligned target: pc_q <= redirect_pc_i with bits [1:0] cleared; IF/ID <= {valid=1, inst=NOP_INST, pc=redirect_pc_i unmodified, fault=1, cause=2}; state <= FAULT.
  - Redirect coincident with a stall overrides the stall; the held entry is dropped.
  - Redirect coincident with oor: the redirect wins and no oor fault is recorded.
- Latency: an instruction at PC p appears on id_inst_o one cycle after pc_q=p, provided advance=1 in that cycle. The first instruction after a redirect appears two cycles after redirect_i.
- A valid entry on id_* never changes while id_valid_o=1 and id_ready_i=0.

Decomposition:
- Shared package core_pkg holds: typedef if_id_t {valid, inst[31:0], pc[31:0], fault, cause[1:0]}; enum fetch_state_e {RUN, FAULT}; enum fault_cause_e {FC_NONE, FC_OOR, FC_MISALIGN}; localparam NOP_INST.
- One sub-module is natural: pc_gen, covering the pc_q register, next-PC mux, alignment and range check. The IF/ID register and FSM stay in fetch_unit.

Test Plan:
- Reset then id_ready_i=1 constantly, memory words 0..3 = 0x11,0x22,0x33,0x44 -> id_inst_o 0x11,0x22,0x33 on consecutive cycles with id_pc_o 0,4,8; imem_addr_o 0,4,8,12.
- Hold id_ready_i=0 for 3 cycles while id_pc_o=4 -> id_inst_o, id_pc_o and imem_addr_o=8 frozen; release -> id_pc_o=8 next cycle.
- redirect_i=1, redirect_pc_i=0x40, during a stall -> next cycle id_valid_o=0, imem_addr_o=0x40; following cycle id_pc_o=0x40.
- Free-run to address 4*101=0x194 -> entry with id_fault_o=1, cause=1, id_inst_o=0x13, id_pc_o=0x194; afterwards id_valid_o stays 0 and imem_addr_o stays 0x194 until redirect to 0 resumes fetch.
- redirect_pc_i=0x22 -> fault entry with cause=2, id_pc_o=0x22, imem_addr_o=0x20; fetch stays halted.
- Assert rst_n=0 asynchronously mid-stream with id_valid_o=1 -> id_valid_o=0 and imem_addr_o=RESET_PC without waiting for a clock edge.
